// File: rtl/muldiv_ctrl.sv
// Sequencer between the execute stage and an unsigned multi-cycle mul/div unit:
// decodes RV32M funct3, issues one multu/divu on magnitudes, then sign-corrects the result.
module muldiv_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        md_valid,
  output logic        md_mode,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ready,
  input  logic [63:0] md_out
);
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ISSUE, S_WAIT, S_FIX, S_RESP, S_DRAIN
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  state_t             state, state_nxt;
  logic [2:0]         funct3_q;
  logic signed [31:0] rs1_q, rs2_q;
  logic               neg_a_q, neg_b_q;
  logic [31:0]        md_a_q, md_b_q;
  logic [63:0]        prod_q;
  logic [31:0]        res_q, data_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic        neg_a_c, neg_b_c, div0, ovf, bypass, timeout, sign_x;
  logic [31:0] byp_res, fix_res;
  logic [63:0] prod_fix;

  // Operand decode and special-case bypass, evaluated while in PREP
  always_comb begin
    neg_a_c = (rs1_q < 0) && ((funct3_q == F_MULH) || (funct3_q == F_MULHSU) ||
                              (funct3_q == F_DIV)  || (funct3_q == F_REM));
    neg_b_c = (rs2_q < 0) && ((funct3_q == F_MULH) || (funct3_q == F_DIV) ||
                              (funct3_q == F_REM));
    div0    = funct3_q[2] && ($unsigned(rs2_q) == 32'd0);
    ovf     = ((funct3_q == F_DIV) || (funct3_q == F_REM)) &&
              ($unsigned(rs1_q) == 32'h8000_0000) && ($unsigned(rs2_q) == 32'hFFFF_FFFF);
    bypass  = div0 || ovf;
    if (div0) byp_res = funct3_q[1] ? $unsigned(rs1_q) : 32'hFFFF_FFFF;
    else      byp_res = funct3_q[1] ? 32'd0 : 32'h8000_0000;
  end

  // Sign correction of the captured unit result, evaluated while in FIX
  always_comb begin
    sign_x   = neg_a_q ^ neg_b_q;
    prod_fix = sign_x ? neg64(prod_q) : prod_q;
    case (funct3_q)
      F_MUL:                     fix_res = prod_q[31:0];
      F_MULH, F_MULHSU, F_MULHU: fix_res = prod_fix[63:32];
      F_DIV, F_DIVU:             fix_res = sign_x ? neg32(prod_q[31:0]) : prod_q[31:0];
      default:                   fix_res = neg_a_q ? neg32(prod_q[63:32]) : prod_q[63:32];
    endcase
  end

  assign timeout = (cnt_q == CNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid && !flush) state_nxt = S_PREP;
      S_PREP:  state_nxt = flush ? S_IDLE : (bypass ? S_RESP : S_ISSUE);
      S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        // A flush that coincides with completion or timeout has nothing left to drain
        if (flush)         state_nxt = (md_ready || timeout) ? S_IDLE : S_DRAIN;
        else if (md_ready) state_nxt = S_FIX;
        else if (timeout)  state_nxt = S_RESP;
      end
      S_FIX:   state_nxt = flush ? S_IDLE : S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_DRAIN: if (md_ready || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    md_valid   = (state == S_ISSUE);
    resp_valid = (state == S_RESP) && !flush;
    resp_data  = resp_valid ? res_q : data_q;
    resp_err   = resp_valid && err_q;
    md_mode    = funct3_q[2];
    md_a       = md_a_q;
    md_b       = md_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      md_a_q   <= '0;
      md_b_q   <= '0;
      prod_q   <= '0;
      res_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid && !flush) begin
          funct3_q <= req_funct3;
          rs1_q    <= signed'(req_rs1);
          rs2_q    <= signed'(req_rs2);
        end
        S_PREP: begin
          neg_a_q <= neg_a_c;
          neg_b_q <= neg_b_c;
          md_a_q  <= neg_a_c ? neg32($unsigned(rs1_q)) : $unsigned(rs1_q);
          md_b_q  <= neg_b_c ? neg32($unsigned(rs2_q)) : $unsigned(rs2_q);
          if (bypass) begin
            res_q <= byp_res;
            err_q <= 1'b0;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (md_ready) prod_q <= md_out;
          else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        S_DRAIN: cnt_q <= cnt_q + CNT_W'(1);
        S_FIX: begin
          res_q <= fix_res;
          err_q <= 1'b0;
        end
        S_RESP: if (!flush) data_q <= res_q;
        default: ;
      endcase
    end
  end

endmodule
